dcache_ctrl: RTL and testbench

- Sequences a direct-indexed, multi-way data cache array (tag/data/valid/LRU storage with separate memory-fill and LSQ-write ports) on behalf of the LSQ.
- Accepts one load or store at a time and probes the array.
- On a miss, fetches the 64-bit line from tagged-response memory and fills it, then replays the lookup.
- Stores are write-allocate and write-through: the array is updated and the merged 64-bit line is written to memory.

---
 rtl/dcache_ctrl.sv | 263 ++++++++++++++++++++++++++
 tb/tb_dcache_ctrl.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_ctrl.sv
// dcache_ctrl: sequences a multi-way data cache array for the LSQ.
// One load/store at a time; misses fetch the 64-bit line from tagged
// memory, fill it and replay the lookup. Stores are write-allocate and
// write-through (array updated, merged line written to memory).
// Optional build macro: DCACHE_CTRL_PERF_EN adds perf_hits/perf_misses.
module dcache_ctrl #(
  parameter int IDX_WIDTH = 5,
  parameter int TAG_WIDTH = 27
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 lsq_req_valid,
  output logic                 lsq_req_ready,
  input  logic                 lsq_req_is_store,
  input  logic [31:0]          lsq_req_addr,
  input  logic [2:0]           lsq_req_size,
  input  logic [31:0]          lsq_req_data,
  output logic                 lsq_resp_valid,
  output logic [31:0]          lsq_resp_data,
  output logic                 cache_rd_en,
  output logic [IDX_WIDTH-1:0] cache_rd_idx,
  output logic [TAG_WIDTH-1:0] cache_rd_tag,
  input  logic                 cache_rd_valid,
  input  logic [63:0]          cache_rd_data,
  output logic                 cache_wr_en_mem,
  output logic                 cache_wr_en_lsq,
  output logic [IDX_WIDTH-1:0] cache_wr_idx,
  output logic [TAG_WIDTH-1:0] cache_wr_tag,
  output logic [63:0]          cache_wr_data,
  output logic [2:0]           cache_size,
  output logic                 cache_offset,
  output logic [1:0]           proc2mem_command,
  output logic [31:0]          proc2mem_addr,
  output logic [63:0]          proc2mem_data,
  input  logic [3:0]           mem2proc_response,
  input  logic [3:0]           mem2proc_tag,
  input  logic [63:0]          mem2proc_data
`ifdef DCACHE_CTRL_PERF_EN
  ,
  output logic [31:0]          perf_hits,
  output logic [31:0]          perf_misses
`endif
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOOKUP, S_MISS_REQ, S_MISS_WAIT, S_FILL, S_ST_WR, S_ST_MEM, S_RESP
  } state_e;

  state_e      state_q, state_d;
  logic        is_store_q, is_store_d;
  logic [31:0] addr_q, addr_d;
  logic [2:0]  size_q, size_d;
  logic [31:0] data_q, data_d;
  logic [3:0]  mem_tag_q, mem_tag_d;
  logic [63:0] line_q, line_d;       // fill line, then merged store line
  logic [31:0] resp_data_q, resp_data_d;

  // Pick the addressed word/half/byte out of a line and extend it.
  function automatic logic [31:0] load_extract(input logic [63:0] line,
                                               input logic [2:0] a,
                                               input logic [2:0] sz);
    logic [31:0] w;
    logic [31:0] sh;
    logic [31:0] res;
    w  = a[2] ? line[63:32] : line[31:0];
    sh = w >> {a[1:0], 3'b000};
    case (sz[1:0])
      2'b00:   res = sz[2] ? {24'h000000, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
      2'b01:   res = sz[2] ? {16'h0000, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
      default: res = w;
    endcase
    return res;
  endfunction

  // Substitute right-aligned store bytes into a line at byte offset a.
  function automatic logic [63:0] store_merge(input logic [63:0] line,
                                              input logic [2:0] a,
                                              input logic [2:0] sz,
                                              input logic [31:0] d);
    logic [63:0] mask;
    logic [63:0] wd;
    logic [5:0]  sh;
    sh = {a, 3'b000};
    case (sz[1:0])
      2'b00:   begin mask = 64'h0000_0000_0000_00FF; wd = {56'h0, d[7:0]};  end
      2'b01:   begin mask = 64'h0000_0000_0000_FFFF; wd = {48'h0, d[15:0]}; end
      default: begin mask = 64'h0000_0000_FFFF_FFFF; wd = {32'h0, d};       end
    endcase
    return (line & ~(mask << sh)) | (wd << sh);
  endfunction

  // State and datapath registers; reset abandons any transaction in flight.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      is_store_q  <= 1'b0;
      addr_q      <= 32'h0;
      size_q      <= 3'b000;
      data_q      <= 32'h0;
      mem_tag_q   <= 4'h0;
      line_q      <= 64'h0;
      resp_data_q <= 32'h0;
    end else begin
      state_q     <= state_d;
      is_store_q  <= is_store_d;
      addr_q      <= addr_d;
      size_q      <= size_d;
      data_q      <= data_d;
      mem_tag_q   <= mem_tag_d;
      line_q      <= line_d;
      resp_data_q <= resp_data_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d     = state_q;
    is_store_d  = is_store_q;
    addr_d      = addr_q;
    size_d      = size_q;
    data_d      = data_q;
    mem_tag_d   = mem_tag_q;
    line_d      = line_q;
    resp_data_d = resp_data_q;
    case (state_q)
      S_IDLE: begin
        if (lsq_req_valid) begin
          is_store_d = lsq_req_is_store;
          addr_d     = lsq_req_addr;
          size_d     = lsq_req_size;
          data_d     = lsq_req_data;
          state_d    = S_LOOKUP;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOOKUP: begin
        if (!cache_rd_valid) begin
          state_d = S_MISS_REQ;
        end else if (is_store_q) begin
          line_d  = store_merge(cache_rd_data, addr_q[2:0], size_q, data_q);
          state_d = S_ST_WR;
        end else begin
          resp_data_d = load_extract(cache_rd_data, addr_q[2:0], size_q);
          state_d     = S_RESP;
        end
      end
      S_MISS_REQ: begin
        if (mem2proc_response != 4'h0) begin
          mem_tag_d = mem2proc_response;
          state_d   = S_MISS_WAIT;
        end else begin
          state_d = S_MISS_REQ;
        end
      end
      S_MISS_WAIT: begin
        if ((mem2proc_tag == mem_tag_q) && (mem_tag_q != 4'h0)) begin
          line_d  = mem2proc_data;
          state_d = S_FILL;
        end else begin
          state_d = S_MISS_WAIT;
        end
      end
      S_FILL:  state_d = S_LOOKUP;
      S_ST_WR: state_d = S_ST_MEM;
      S_ST_MEM: begin
        if (mem2proc_response != 4'h0) begin
          state_d = S_RESP;
        end else begin
          state_d = S_ST_MEM;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State-decoded strobes and data buses.
  always_comb begin
    lsq_req_ready    = 1'b0;
    lsq_resp_valid   = 1'b0;
    cache_rd_en      = 1'b0;
    cache_wr_en_mem  = 1'b0;
    cache_wr_en_lsq  = 1'b0;
    cache_wr_data    = 64'h0;
    proc2mem_command = 2'd0;
    proc2mem_data    = 64'h0;
    case (state_q)
      S_IDLE:     lsq_req_ready = 1'b1;
      S_LOOKUP:   cache_rd_en = 1'b1;
      S_MISS_REQ: proc2mem_command = 2'd1;
      S_FILL: begin
        cache_wr_en_mem = 1'b1;
        cache_wr_data   = line_q;
      end
      S_ST_WR: begin
        cache_wr_en_lsq = 1'b1;
        cache_wr_data   = {32'h0, data_q};
      end
      S_ST_MEM: begin
        proc2mem_command = 2'd2;
        proc2mem_data    = line_q;
      end
      S_RESP:  lsq_resp_valid = 1'b1;
      default: lsq_req_ready = 1'b0;
    endcase
  end

  assign lsq_resp_data = resp_data_q;
  assign cache_rd_idx  = addr_q[IDX_WIDTH+2:3];
  assign cache_rd_tag  = addr_q[31:IDX_WIDTH+3];
  assign cache_wr_idx  = addr_q[IDX_WIDTH+2:3];
  assign cache_wr_tag  = addr_q[31:IDX_WIDTH+3];
  assign cache_size    = size_q;
  assign cache_offset  = addr_q[2];
  assign proc2mem_addr = {addr_q[31:3], 3'b000};

`ifdef DCACHE_CTRL_PERF_EN
  logic        first_q, first_d;
  logic [31:0] hits_q, hits_d;
  logic [31:0] misses_q, misses_d;

  // Count only the first probe of each request; saturate at all-ones.
  always_comb begin
    first_d  = first_q;
    hits_d   = hits_q;
    misses_d = misses_q;
    if (state_q == S_IDLE && lsq_req_valid) begin
      first_d = 1'b1;
    end else if (state_q == S_LOOKUP) begin
      first_d = 1'b0;
      if (first_q && cache_rd_valid && hits_q != 32'hFFFF_FFFF) begin
        hits_d = hits_q + 32'd1;
      end else if (first_q && !cache_rd_valid && misses_q != 32'hFFFF_FFFF) begin
        misses_d = misses_q + 32'd1;
      end else begin
        hits_d = hits_q;
      end
    end else begin
      first_d = first_q;
    end
  end

  // Performance counter registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      first_q  <= 1'b0;
      hits_q   <= 32'h0;
      misses_q <= 32'h0;
    end else begin
      first_q  <= first_d;
      hits_q   <= hits_d;
      misses_q <= misses_d;
    end
  end

  assign perf_hits   = hits_q;
  assign perf_misses = misses_q;
`else
  // Performance counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed self-checking bench for dcache_ctrl with a small behavioural
// cache array (filled only by cache_wr_en_mem) and hand-driven memory.
module tb_dcache_ctrl;
  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        lsq_req_valid = 1'b0;
  logic        lsq_req_ready;
  logic        lsq_req_is_store = 1'b0;
  logic [31:0] lsq_req_addr = 32'h0;
  logic [2:0]  lsq_req_size = 3'b000;
  logic [31:0] lsq_req_data = 32'h0;
  logic        lsq_resp_valid;
  logic [31:0] lsq_resp_data;
  logic        cache_rd_en;
  logic [4:0]  cache_rd_idx;
  logic [26:0] cache_rd_tag;
  logic        cache_rd_valid;
  logic [63:0] cache_rd_data;
  logic        cache_wr_en_mem, cache_wr_en_lsq;
  logic [4:0]  cache_wr_idx;
  logic [26:0] cache_wr_tag;
  logic [63:0] cache_wr_data;
  logic [2:0]  cache_size;
  logic        cache_offset;
  logic [1:0]  proc2mem_command;
  logic [31:0] proc2mem_addr;
  logic [63:0] proc2mem_data;
  logic [3:0]  mem2proc_response = 4'h0;
  logic [3:0]  mem2proc_tag = 4'h0;
  logic [63:0] mem2proc_data = 64'h0;

  int tests_run = 0;
  int tests_failed = 0;
  int fill_cnt = 0;
  int resp_cnt = 0;
  int cmd_cnt = 0;

  logic        mv    [32];
  logic [26:0] mtag  [32];
  logic [63:0] mdata [32];

  dcache_ctrl dut (
    .clock(clock), .reset(reset),
    .lsq_req_valid(lsq_req_valid), .lsq_req_ready(lsq_req_ready),
    .lsq_req_is_store(lsq_req_is_store), .lsq_req_addr(lsq_req_addr),
    .lsq_req_size(lsq_req_size), .lsq_req_data(lsq_req_data),
    .lsq_resp_valid(lsq_resp_valid), .lsq_resp_data(lsq_resp_data),
    .cache_rd_en(cache_rd_en), .cache_rd_idx(cache_rd_idx), .cache_rd_tag(cache_rd_tag),
    .cache_rd_valid(cache_rd_valid), .cache_rd_data(cache_rd_data),
    .cache_wr_en_mem(cache_wr_en_mem), .cache_wr_en_lsq(cache_wr_en_lsq),
    .cache_wr_idx(cache_wr_idx), .cache_wr_tag(cache_wr_tag), .cache_wr_data(cache_wr_data),
    .cache_size(cache_size), .cache_offset(cache_offset),
    .proc2mem_command(proc2mem_command), .proc2mem_addr(proc2mem_addr),
    .proc2mem_data(proc2mem_data), .mem2proc_response(mem2proc_response),
    .mem2proc_tag(mem2proc_tag), .mem2proc_data(mem2proc_data)
  );

  always #5 clock = ~clock;

  // Cache array model: combinational probe, fills on cache_wr_en_mem.
  assign cache_rd_valid = cache_rd_en && mv[cache_rd_idx] && (mtag[cache_rd_idx] == cache_rd_tag);
  assign cache_rd_data  = mdata[cache_rd_idx];

  always @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) mv[i] <= 1'b0;
    end else if (cache_wr_en_mem) begin
      mv[cache_wr_idx]    <= 1'b1;
      mtag[cache_wr_idx]  <= cache_wr_tag;
      mdata[cache_wr_idx] <= cache_wr_data;
    end
  end

  // Event counters for fill pulses, responses and memory commands.
  always @(posedge clock) begin
    if (cache_wr_en_mem) fill_cnt <= fill_cnt + 1;
    if (lsq_resp_valid) resp_cnt <= resp_cnt + 1;
    if (proc2mem_command != 2'd0) cmd_cnt <= cmd_cnt + 1;
  end

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  // Present one request in IDLE; returns with the DUT in LOOKUP.
  task automatic start_req(input logic st, input logic [31:0] a,
                           input logic [2:0] sz, input logic [31:0] d);
    lsq_req_valid = 1'b1; lsq_req_is_store = st;
    lsq_req_addr = a; lsq_req_size = sz; lsq_req_data = d;
    tests_run++;
    if (lsq_req_ready !== 1'b1) begin tests_failed++; $display("FAIL req_ready: got %b want 1", lsq_req_ready); end
    tick;
    lsq_req_valid = 1'b0;
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clock);
    #1;
    tests_run++;
    if (lsq_req_ready !== 1'b1) begin tests_failed++; $display("FAIL rst_ready: got %b want 1", lsq_req_ready); end
    tests_run++;
    if ({lsq_resp_valid, cache_rd_en, cache_wr_en_mem, cache_wr_en_lsq, proc2mem_command} !== 6'b0) begin
      tests_failed++; $display("FAIL rst_strobes: got %b want 0",
        {lsq_resp_valid, cache_rd_en, cache_wr_en_mem, cache_wr_en_lsq, proc2mem_command});
    end
    tests_run++;
    if ({proc2mem_addr, lsq_resp_data, proc2mem_data, cache_wr_data} !== 192'h0) begin
      tests_failed++; $display("FAIL rst_buses: got %h want 0", {proc2mem_addr, lsq_resp_data, proc2mem_data, cache_wr_data});
    end
    reset = 1'b1;
    tick;
  endtask

  task automatic test_cold_load;
    int f0;
    f0 = fill_cnt;
    start_req(1'b0, 32'h0000_1004, 3'b010, 32'h0);
    tests_run++;
    if ({cache_rd_en, cache_rd_idx, cache_rd_tag} !== {1'b1, 5'd0, 27'h10}) begin
      tests_failed++; $display("FAIL cold_probe: got %b/%h/%h want 1/00/10", cache_rd_en, cache_rd_idx, cache_rd_tag);
    end
    tick;
    tests_run++;
    if (proc2mem_command !== 2'd1 || proc2mem_addr !== 32'h0000_1000) begin
      tests_failed++; $display("FAIL cold_memreq: got %0d/%h want 1/00001000", proc2mem_command, proc2mem_addr);
    end
    tick;
    tests_run++;
    if (proc2mem_command !== 2'd1) begin tests_failed++; $display("FAIL cold_hold: got %0d want 1", proc2mem_command); end
    mem2proc_response = 4'd3;
    tick;
    mem2proc_response = 4'd0;
    tests_run++;
    if (proc2mem_command !== 2'd0) begin tests_failed++; $display("FAIL cold_wait_cmd: got %0d want 0", proc2mem_command); end
    mem2proc_tag = 4'd3; mem2proc_data = 64'h1122_3344_5566_7788;
    tick;
    mem2proc_tag = 4'd0; mem2proc_data = 64'h0;
    tests_run++;
    if (cache_wr_en_mem !== 1'b1 || cache_wr_data !== 64'h1122_3344_5566_7788 || cache_wr_tag !== 27'h10) begin
      tests_failed++; $display("FAIL cold_fill: got %b/%h/%h want 1/1122334455667788/10", cache_wr_en_mem, cache_wr_data, cache_wr_tag);
    end
    tick;
    tests_run++;
    if (cache_wr_en_mem !== 1'b0 || cache_rd_en !== 1'b1) begin
      tests_failed++; $display("FAIL cold_replay: got wr_en_mem %b rd_en %b want 0/1", cache_wr_en_mem, cache_rd_en);
    end
    tick;
    tests_run++;
    if (lsq_resp_valid !== 1'b1 || lsq_resp_data !== 32'h1122_3344) begin
      tests_failed++; $display("FAIL cold_resp: got %b/%h want 1/11223344", lsq_resp_valid, lsq_resp_data);
    end
    tests_run++;
    if (fill_cnt - f0 !== 1) begin tests_failed++; $display("FAIL cold_fill_count: got %0d want 1", fill_cnt - f0); end
    tick;
    tests_run++;
    if (lsq_req_ready !== 1'b1 || lsq_resp_valid !== 1'b0) begin
      tests_failed++; $display("FAIL cold_idle: got ready %b resp %b want 1/0", lsq_req_ready, lsq_resp_valid);
    end
  endtask

  // Hit load: response visible in the third cycle counting the handshake cycle.
  task automatic test_hit_load;
    int c0;
    int n;
    c0 = cmd_cnt;
    start_req(1'b0, 32'h0000_1004, 3'b010, 32'h0);
    n = 0;
    while (lsq_resp_valid !== 1'b1 && n < 8) begin tick; n++; end
    tests_run++;
    if (n !== 1) begin tests_failed++; $display("FAIL hit_latency: got %0d want 1 cycle after LOOKUP", n); end
    tests_run++;
    if (lsq_resp_data !== 32'h1122_3344) begin tests_failed++; $display("FAIL hit_data: got %h want 11223344", lsq_resp_data); end
    tests_run++;
    if (cmd_cnt !== c0) begin tests_failed++; $display("FAIL hit_no_mem: got %0d commands want 0", cmd_cnt - c0); end
    tick;
  endtask

  task automatic test_store_hit;
    start_req(1'b1, 32'h0000_1001, 3'b000, 32'h0000_00AB);
    tick;
    tests_run++;
    if ({cache_wr_en_lsq, cache_wr_en_mem, cache_offset, cache_size} !== 6'b10_0_000 || cache_wr_data !== 64'h0000_0000_0000_00AB) begin
      tests_failed++; $display("FAIL st_wr: got lsq %b mem %b off %b size %b data %h want 1 0 0 000 ab",
        cache_wr_en_lsq, cache_wr_en_mem, cache_offset, cache_size, cache_wr_data);
    end
    tick;
    tests_run++;
    if (proc2mem_command !== 2'd2 || proc2mem_data !== 64'h1122_3344_5566_AB88 || proc2mem_addr !== 32'h0000_1000) begin
      tests_failed++; $display("FAIL st_mem: got %0d/%h/%h want 2/112233445566ab88/00001000", proc2mem_command, proc2mem_data, proc2mem_addr);
    end
    tick;
    tests_run++;
    if (proc2mem_command !== 2'd2 || lsq_resp_valid !== 1'b0) begin
      tests_failed++; $display("FAIL st_stall: got cmd %0d resp %b want 2/0", proc2mem_command, lsq_resp_valid);
    end
    mem2proc_response = 4'd1;
    tick;
    mem2proc_response = 4'd0;
    tests_run++;
    if (lsq_resp_valid !== 1'b1 || proc2mem_command !== 2'd0) begin
      tests_failed++; $display("FAIL st_resp: got resp %b cmd %0d want 1/0", lsq_resp_valid, proc2mem_command);
    end
    tick;
  endtask

  task automatic test_store_miss;
    start_req(1'b1, 32'h0000_200E, 3'b001, 32'h0000_BEEF);
    tick;
    mem2proc_response = 4'd5;
    tick;
    mem2proc_response = 4'd0;
    mem2proc_tag = 4'd2; mem2proc_data = 64'hDEAD_DEAD_DEAD_DEAD;
    tick;
    tests_run++;
    if (cache_wr_en_mem !== 1'b0) begin tests_failed++; $display("FAIL stm_ignore_tag2: got wr_en_mem %b want 0", cache_wr_en_mem); end
    mem2proc_tag = 4'd5; mem2proc_data = 64'hA0A1_A2A3_A4A5_A6A7;
    tick;
    mem2proc_tag = 4'd0; mem2proc_data = 64'h0;
    tests_run++;
    if (cache_wr_en_mem !== 1'b1 || cache_wr_data !== 64'hA0A1_A2A3_A4A5_A6A7 || cache_wr_idx !== 5'd1) begin
      tests_failed++; $display("FAIL stm_fill: got %b/%h/%h want 1/a0a1a2a3a4a5a6a7/01", cache_wr_en_mem, cache_wr_data, cache_wr_idx);
    end
    tick;
    tick;
    tests_run++;
    if (cache_wr_en_lsq !== 1'b1 || cache_offset !== 1'b1 || cache_size !== 3'b001 || cache_wr_data !== 64'h0000_0000_0000_BEEF) begin
      tests_failed++; $display("FAIL stm_wr: got %b/%b/%b/%h want 1/1/001/beef", cache_wr_en_lsq, cache_offset, cache_size, cache_wr_data);
    end
    tick;
    tests_run++;
    if (proc2mem_command !== 2'd2 || proc2mem_data !== 64'hBEEF_A2A3_A4A5_A6A7) begin
      tests_failed++; $display("FAIL stm_mem: got %0d/%h want 2/beefa2a3a4a5a6a7", proc2mem_command, proc2mem_data);
    end
    mem2proc_response = 4'd5;
    tick;
    mem2proc_response = 4'd0;
    tests_run++;
    if (lsq_resp_valid !== 1'b1) begin tests_failed++; $display("FAIL stm_resp: got %b want 1", lsq_resp_valid); end
    tick;
  endtask

  task automatic test_load_sign;
    logic [31:0] la [4];
    logic [2:0]  ls [4];
    logic [31:0] le [4];
    la[0] = 32'h0000_3011; ls[0] = 3'b000; le[0] = 32'hFFFF_FF80;
    la[1] = 32'h0000_3011; ls[1] = 3'b100; le[1] = 32'h0000_0080;
    la[2] = 32'h0000_3012; ls[2] = 3'b001; le[2] = 32'hFFFF_9ABC;
    la[3] = 32'h0000_3014; ls[3] = 3'b010; le[3] = 32'h1234_5678;
    // First access misses and brings in the line.
    start_req(1'b0, la[0], ls[0], 32'h0);
    tick;
    mem2proc_response = 4'd1;
    tick;
    mem2proc_response = 4'd0;
    mem2proc_tag = 4'd1; mem2proc_data = 64'h1234_5678_9ABC_80EF;
    tick;
    mem2proc_tag = 4'd0; mem2proc_data = 64'h0;
    tick;
    tick;
    tests_run++;
    if (lsq_resp_valid !== 1'b1 || lsq_resp_data !== le[0]) begin
      tests_failed++; $display("FAIL sign_byte: got %b/%h want 1/%h", lsq_resp_valid, lsq_resp_data, le[0]);
    end
    tick;
    for (int k = 1; k < 4; k++) begin
      start_req(1'b0, la[k], ls[k], 32'h0);
      tick;
      tests_run++;
      if (lsq_resp_valid !== 1'b1 || lsq_resp_data !== le[k]) begin
        tests_failed++; $display("FAIL ext_load%0d: got %b/%h want 1/%h", k, lsq_resp_valid, lsq_resp_data, le[k]);
      end
      tick;
    end
  endtask

  task automatic test_reset_mid;
    int f0;
    int r0;
    f0 = fill_cnt;
    r0 = resp_cnt;
    start_req(1'b0, 32'h0000_4000, 3'b010, 32'h0);
    tick;
    mem2proc_response = 4'd7;
    tick;
    mem2proc_response = 4'd0;
    reset = 1'b0;
    #1;
    tests_run++;
    if (lsq_req_ready !== 1'b1 || proc2mem_command !== 2'd0 || cache_rd_en !== 1'b0) begin
      tests_failed++; $display("FAIL rmid_ctrl: got ready %b cmd %0d rd_en %b want 1/0/0", lsq_req_ready, proc2mem_command, cache_rd_en);
    end
    tests_run++;
    if (lsq_resp_data !== 32'h0 || proc2mem_addr !== 32'h0) begin
      tests_failed++; $display("FAIL rmid_buses: got %h/%h want 0/0", lsq_resp_data, proc2mem_addr);
    end
    tick;
    reset = 1'b1;
    mem2proc_tag = 4'd7; mem2proc_data = 64'h5555_5555_5555_5555;
    tick;
    mem2proc_tag = 4'd0; mem2proc_data = 64'h0;
    tests_run++;
    if (cache_wr_en_mem !== 1'b0 || lsq_req_ready !== 1'b1) begin
      tests_failed++; $display("FAIL rmid_return: got wr_en_mem %b ready %b want 0/1", cache_wr_en_mem, lsq_req_ready);
    end
    repeat (3) tick;
    tests_run++;
    if (fill_cnt !== f0 || resp_cnt !== r0) begin
      tests_failed++; $display("FAIL rmid_quiet: got fills %0d resps %0d want 0/0", fill_cnt - f0, resp_cnt - r0);
    end
  endtask

  initial begin
    test_reset;
    test_cold_load;
    test_hit_load;
    test_store_hit;
    test_store_miss;
    test_load_sign;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
